uart_core_cfg: RTL and testbench
================================

# uart_core_cfg

Runtime-configurable UART core: an integrated baud tick generator, a 16x-oversampled receiver and a transmitter, with a parametrised FWFT FIFO on each direction. Frame format is selectable at run time: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. The receiver reports sticky parity, framing and overrun errors. The core sits between a host register interface and the board-level rx/tx pins.

## Interface
- `DIV_W`, 11: width of the baud divisor.
- `FIFO_AW`, 4: FIFO address width; depth of each FIFO is 2**FIFO_AW.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 8.
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `cfg_divisor` in DIV_W: tick period is cfg_divisor+1 clocks.
- `cfg_data_bits` in 2: 00=5, 01=6, 10=7, 11=8 data bits.
- `cfg_parity` in 2: 00=none, 01=even, 10=odd, 11=none.
- `cfg_stop2` in 1: 1 selects two stop bits.
- `w_data` in 8: transmit byte; only the low N bits are sent.
- `wr_uart` in 1: push `w_data` into the TX FIFO.
- `tx_full` out 1: TX FIFO is full.
- `tx_busy` out 1: a TX frame is in progress.
- `tx` out 1: serial output.
- `rx` in 1: serial input, asynchronous.
- `rd_uart` in 1: pop the RX FIFO head.
- `rx_data` out 8: RX FIFO head (FWFT); bits above N are 0.
- `rx_empty` out 1: RX FIFO is empty.
- `rx_parity_err` out 1: sticky parity error flag.
- `rx_frame_err` out 1: sticky framing error flag.
- `rx_overrun` out 1: sticky overrun flag.
- `clr_err` in 1: clears all three sticky error flags.

## Operation
- Tick generator: free-running counter from 0 to cfg_divisor. `tick` is high for one clock when counter == cfg_divisor; the counter then returns to 0.
- Configuration (`cfg_*`) is sampled per direction when a frame starts. Changing it mid-frame has no effect on that frame.
- `rx` passes through a 2-FF synchroniser before use.
- RX FSM:
  - IDLE → START on synchronised rx = 0. Tick count is reset on entry.
  - START: after OVERSAMPLE/2 ticks, re-sample rx. If rx = 1 (glitch), go to IDLE with nothing stored. If rx = 0, go to DATA.
  - DATA: sample every OVERSAMPLE ticks, LSB first, N bits. Then go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: sample one bit. Mismatch against the even/odd parity of the data sets `rx_parity_err`.
  - STOP: sample 1 or 2 stop bits. Any stop sample of 0 sets `rx_frame_err`.
  - On the cycle after the last stop sample, the byte is written to the RX FIFO (even if an error was flagged) and the FSM returns to IDLE.
- RX FIFO full at write time: the new byte is dropped and `rx_overrun` is set.
- TX FSM:
  - IDLE: when the TX FIFO is not empty, pop the head into the shift register, latch cfg, and go to START.
  - START: drive 0 for OVERSAMPLE ticks.
  - DATA: N bits, LSB first.
  - PARITY: sent only if enabled.
  - STOP: 1 or 2 stop bits of 1, then return to IDLE.
  - `tx_busy` is high in every state except IDLE.
- FIFOs:
  - First-word-fall-through.
  - Write to a full FIFO is ignored; read from an empty FIFO is ignored.
  - Simultaneous read and write on a full or empty FIFO both take effect; occupancy is unchanged.
  - Pointers wrap modulo 2**FIFO_AW. Full/empty are derived from an (FIFO_AW+1)-bit occupancy count.
- Sticky errors: `clr_err` has priority over a same-cycle set, so the flag reads 0 on the next cycle.

## Timing
- Reset values (applied the cycle after `reset_n` is sampled low):
  - tx = 1; tx_busy = 0; tx_full = 0; rx_empty = 1; rx_data = 0; all error flags 0.
  - Both FSMs in IDLE; both FIFOs empty; tick counter 0.
- Reset mid-frame aborts immediately. No partial byte is stored; tx returns to 1.
- Bit period is OVERSAMPLE × (cfg_divisor+1) clocks.
- TX: a write to an empty FIFO while TX is idle is popped one cycle later. `tx` falls on the cycle after the pop.
- RX: a byte is visible on `rx_data` with `rx_empty` = 0 one cycle after the FIFO write. Pin-to-FSM synchroniser latency is 2 clocks.
- `tx_full` and `rx_empty` are registered and update the cycle after the push or pop.

## Test plan
- Loopback (tx→rx), divisor 3, 8N1, write 0xA5:
  - tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 64 clocks.
  - rx_data = 0xA5; no error flags set.
- 7E2, write 0x35:
  - Parity bit is 0 and two stop bits are sent; receiver returns 0x35.
  - Repeat with the bench flipping the parity bit: rx_parity_err = 1 and 0x35 is still stored.
  - Pulse clr_err: the flag clears the next cycle.
- Drive 8N1 0x3C with the stop bit held 0:
  - rx_frame_err = 1 and rx_data = 0x3C.
  - A low pulse of 4 ticks on an idle line: no byte, no error.
- FIFO_AW = 4, receive 17 bytes 0x00..0x10 with no reads:
  - 16 entries 0x00..0x0F; rx_overrun = 1; 0x10 is dropped.
  - Pop all 16: rx_empty = 1 after the 16th pop.
- Write 17 bytes on consecutive cycles while TX is idle:
  - tx_full = 1 after the 17th write; an 18th write is ignored.
  - All 17 bytes appear on tx in order.
- Assert reset_n = 0 mid-TX-frame and mid-RX-frame:
  - Next cycle: tx = 1, tx_busy = 0, rx_empty = 1, flags 0.
  - After release, a fresh 0x5A frame transfers correctly.

Source files
------------

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: runtime-configurable UART with a shared baud tick,
// 16x oversampled receiver, transmitter and an FWFT FIFO per direction.
module uart_core_cfg #(
    parameter int DIV_W      = 11,
    parameter int FIFO_AW    = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] cfg_divisor,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic [7:0]       w_data,
    input  logic             wr_uart,
    output logic             tx_full,
    output logic             tx_busy,
    output logic             tx,
    input  logic             rx,
    input  logic             rd_uart,
    output logic [7:0]       rx_data,
    output logic             rx_empty,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_overrun,
    input  logic             clr_err
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] OS_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] OS_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == cfg_divisor);

    always_ff @(posedge clk) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    logic rx_meta, rx_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    logic [7:0]         txf_mem [DEPTH];
    logic [FIFO_AW-1:0] txf_wp, txf_rp;
    logic [CW-1:0]      txf_cnt;
    logic               txf_full, txf_empty, txf_we, txf_re;
    logic [7:0]         rxf_mem [DEPTH];
    logic [FIFO_AW-1:0] rxf_wp, rxf_rp;
    logic [CW-1:0]      rxf_cnt;
    logic               rxf_full, rxf_empty, rxf_we, rxf_re;

    // Receiver
    state_t        rx_st, rx_nx;
    logic [SW-1:0] rx_sc;
    logic [2:0]    rx_bc;
    logic [7:0]    rx_sh;
    logic [1:0]    rx_bits, rx_par;
    logic          rx_stop2, rx_wr;
    logic          rx_start, rx_go, rx_end, rx_last_bit, rx_last_stop;
    logic          rx_exp_par, perr_set, ferr_set, ovr_set;

    always_ff @(posedge clk) begin
        if (!reset_n) rx_st <= S_IDLE;
        else          rx_st <= rx_nx;
    end

    always_comb begin
        rx_nx = rx_st;
        unique case (rx_st)
            S_IDLE:  if (!rx_s) rx_nx = S_START;
            S_START: if (tick && rx_sc == OS_HALF)
                         rx_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_end && rx_last_bit)
                         rx_nx = (^rx_par) ? S_PAR : S_STOP;
            S_PAR:   if (rx_end) rx_nx = S_STOP;
            S_STOP:  if (rx_end && rx_last_stop) rx_nx = S_IDLE;
            default: rx_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_end       = tick && (rx_sc == OS_LAST);
        rx_last_bit  = (rx_bc == 3'd4 + {1'b0, rx_bits});
        rx_last_stop = (rx_bc[0] == rx_stop2);
        rx_start     = (rx_st == S_IDLE) && !rx_s;
        rx_go        = (rx_st == S_START) && tick &&
                       (rx_sc == OS_HALF) && !rx_s;
        rx_exp_par   = (^rx_sh) ^ (rx_par == 2'b10);
        perr_set     = (rx_st == S_PAR) && rx_end && (rx_s != rx_exp_par);
        ferr_set     = (rx_st == S_STOP) && rx_end && !rx_s;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sc    <= '0;
            rx_bc    <= '0;
            rx_sh    <= '0;
            rx_bits  <= '0;
            rx_par   <= '0;
            rx_stop2 <= 1'b0;
        end else if (rx_start) begin
            rx_sc    <= '0;
            rx_bc    <= '0;
            rx_sh    <= '0;
            rx_bits  <= cfg_data_bits;
            rx_par   <= cfg_parity;
            rx_stop2 <= cfg_stop2;
        end else if (rx_go) begin
            rx_sc <= '0;
        end else if (tick && rx_st != S_IDLE) begin
            rx_sc <= rx_end ? '0 : rx_sc + 1'b1;
            if (rx_end) begin
                case (rx_st)
                    S_DATA: begin
                        rx_sh[rx_bc] <= rx_s;
                        rx_bc <= rx_last_bit ? '0 : rx_bc + 1'b1;
                    end
                    S_STOP:  rx_bc <= rx_bc + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // The byte lands in the FIFO the cycle after the final stop sample
    always_ff @(posedge clk) begin
        if (!reset_n) rx_wr <= 1'b0;
        else rx_wr <= (rx_st == S_STOP) && rx_end && rx_last_stop;
    end

    assign ovr_set = rx_wr && !rxf_we;

    always_ff @(posedge clk) begin
        if (!reset_n || clr_err) begin
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (perr_set) rx_parity_err <= 1'b1;
            if (ferr_set) rx_frame_err  <= 1'b1;
            if (ovr_set)  rx_overrun    <= 1'b1;
        end
    end

    // Transmitter
    state_t        tx_st, tx_nx;
    logic [SW-1:0] tx_sc;
    logic [2:0]    tx_bc;
    logic [7:0]    tx_sh, tx_mask;
    logic [1:0]    tx_bits, tx_par;
    logic          tx_stop2, tx_pop, tx_end, tx_last_bit, tx_last_stop;

    assign tx_mask = 8'hFF >> (2'd3 - cfg_data_bits);

    always_ff @(posedge clk) begin
        if (!reset_n) tx_st <= S_IDLE;
        else          tx_st <= tx_nx;
    end

    always_comb begin
        tx_nx = tx_st;
        unique case (tx_st)
            S_IDLE:  if (!txf_empty) tx_nx = S_START;
            S_START: if (tx_end) tx_nx = S_DATA;
            S_DATA:  if (tx_end && tx_last_bit)
                         tx_nx = (^tx_par) ? S_PAR : S_STOP;
            S_PAR:   if (tx_end) tx_nx = S_STOP;
            S_STOP:  if (tx_end && tx_last_stop) tx_nx = S_IDLE;
            default: tx_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx_end       = tick && (tx_sc == OS_LAST);
        tx_last_bit  = (tx_bc == 3'd4 + {1'b0, tx_bits});
        tx_last_stop = (tx_bc[0] == tx_stop2);
        tx_pop       = (tx_st == S_IDLE) && !txf_empty;
        tx_busy      = (tx_st != S_IDLE);
        unique case (tx_st)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_sh[tx_bc];
            S_PAR:   tx = (^tx_sh) ^ (tx_par == 2'b10);
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_sc    <= '0;
            tx_bc    <= '0;
            tx_sh    <= '0;
            tx_bits  <= '0;
            tx_par   <= '0;
            tx_stop2 <= 1'b0;
        end else if (tx_pop) begin
            tx_sc    <= '0;
            tx_bc    <= '0;
            tx_sh    <= txf_mem[txf_rp] & tx_mask;
            tx_bits  <= cfg_data_bits;
            tx_par   <= cfg_parity;
            tx_stop2 <= cfg_stop2;
        end else if (tick && tx_st != S_IDLE) begin
            tx_sc <= tx_end ? '0 : tx_sc + 1'b1;
            if (tx_end) begin
                case (tx_st)
                    S_DATA:  tx_bc <= tx_last_bit ? '0 : tx_bc + 1'b1;
                    S_STOP:  tx_bc <= tx_bc + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // FWFT FIFOs
    assign txf_full  = (txf_cnt == CNT_FULL);
    assign txf_empty = (txf_cnt == '0);
    assign txf_we    = wr_uart && (!txf_full || tx_pop);
    assign txf_re    = tx_pop;
    assign tx_full   = txf_full;

    always_ff @(posedge clk) begin
        if (txf_we) txf_mem[txf_wp] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            txf_wp  <= '0;
            txf_rp  <= '0;
            txf_cnt <= '0;
        end else begin
            if (txf_we) txf_wp <= txf_wp + 1'b1;
            if (txf_re) txf_rp <= txf_rp + 1'b1;
            txf_cnt <= txf_cnt + CW'(txf_we) - CW'(txf_re);
        end
    end

    assign rxf_full  = (rxf_cnt == CNT_FULL);
    assign rxf_empty = (rxf_cnt == '0);
    assign rxf_we    = rx_wr && (!rxf_full || rd_uart);
    assign rxf_re    = rd_uart && (!rxf_empty || rx_wr);
    assign rx_empty  = rxf_empty;
    assign rx_data   = rxf_empty ? 8'h00 : rxf_mem[rxf_rp];

    always_ff @(posedge clk) begin
        if (rxf_we) rxf_mem[rxf_wp] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxf_wp  <= '0;
            rxf_rp  <= '0;
            rxf_cnt <= '0;
        end else begin
            if (rxf_we) rxf_wp <= rxf_wp + 1'b1;
            if (rxf_re) rxf_rp <= rxf_rp + 1'b1;
            rxf_cnt <= rxf_cnt + CW'(rxf_we) - CW'(rxf_re);
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// tb_uart_core_cfg: directed checks of uart_core_cfg against a
// frame-level line model and an expected-byte scoreboard.
`timescale 1ns/1ps
module tb_uart_core_cfg;
    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] cfg_divisor;
    logic [1:0]  cfg_data_bits, cfg_parity;
    logic        cfg_stop2;
    logic [7:0]  w_data;
    logic        wr_uart, rd_uart, clr_err;
    logic        tx_full, tx_busy, tx, rx;
    logic [7:0]  rx_data;
    logic        rx_empty, rx_parity_err, rx_frame_err, rx_overrun;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;

    int nvec = 0;
    int nerr = 0;

    assign rx = loop ? tx : rx_drv;

    uart_core_cfg dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_divisor(cfg_divisor), .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .w_data(w_data), .wr_uart(wr_uart),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx),
        .rx(rx), .rd_uart(rd_uart), .rx_data(rx_data),
        .rx_empty(rx_empty), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        nvec++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Line image of one frame, index 0 = start bit; returns frame length.
    function automatic int build_frame(input logic [7:0] d,
                                       input logic [1:0] bits,
                                       input logic [1:0] par,
                                       input logic stop2,
                                       output logic [15:0] f);
        int n;
        int idx;
        logic p;
        n = 5 + int'(bits);
        f = '1;
        f[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            f[1+i] = d[i];
            p ^= d[i];
        end
        idx = 1 + n;
        if (par == 2'b01 || par == 2'b10) begin
            f[idx] = (par == 2'b10) ? ~p : p;
            idx++;
        end
        idx += stop2 ? 2 : 1;
        return idx;
    endfunction

    logic [15:0] fq[$];
    int          lq[$];
    bit          mon_en = 1'b0;
    bit          mon_on = 1'b0;
    int          mon_cnt = 0;
    int          mon_k;
    logic [15:0] cur_f;
    int          cur_l;
    int          frames_seen = 0;

    // Compare process: tx checked at the centre of every expected bit
    always @(negedge clk) begin
        if (mon_en && !mon_on && tx === 1'b0) begin
            if (fq.size() == 0) begin
                check("tx_unexpected_frame", int'(tx), 1);
                mon_en = 1'b0;
            end else begin
                cur_f   = fq.pop_front();
                cur_l   = lq.pop_front();
                mon_on  = 1'b1;
                mon_cnt = 0;
            end
        end
        if (mon_on) begin
            if (mon_cnt % BIT_CLKS == BIT_CLKS / 2) begin
                mon_k = mon_cnt / BIT_CLKS;
                check($sformatf("tx_bit%0d", mon_k), int'(tx),
                      int'(cur_f[mon_k]));
                if (mon_k == cur_l - 1) begin
                    mon_on = 1'b0;
                    frames_seen++;
                end
            end
            mon_cnt++;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic [1:0] p,
                           input logic s2);
        cfg_data_bits = b;
        cfg_parity    = p;
        cfg_stop2     = s2;
    endtask

    task automatic expect_tx(input logic [7:0] d);
        logic [15:0] f;
        int l;
        l = build_frame(d, cfg_data_bits, cfg_parity, cfg_stop2, f);
        fq.push_back(f);
        lq.push_back(l);
    endtask

    task automatic uart_write(input logic [7:0] d);
        @(negedge clk);
        w_data  = d;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic wait_tx_done(input string name);
        int t;
        t = 0;
        while ((fq.size() != 0 || mon_on || tx_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_tx_done"}, fq.size() + int'(mon_on) + int'(tx_busy), 0);
    endtask

    task automatic wait_rx(input string name);
        int t;
        t = 0;
        while (rx_empty && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_rx_avail"}, int'(rx_empty), 0);
    endtask

    task automatic pop_rx(input string name, input logic [7:0] want);
        check(name, int'(rx_data), int'(want));
        @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par,
                              input bit bad_stop);
        logic [15:0] f;
        int l;
        int n;
        l = build_frame(d, cfg_data_bits, cfg_parity, cfg_stop2, f);
        n = 5 + int'(cfg_data_bits);
        if (flip_par) f[1+n] = ~f[1+n];
        for (int i = 0; i < l; i++) begin
            rx_drv = f[i];
            if (bad_stop && i == l - 1) begin
                rx_drv = 1'b0;
                tick_n(48);
                rx_drv = 1'b1;
                tick_n(16);
            end else begin
                tick_n(BIT_CLKS);
            end
        end
        rx_drv = 1'b1;
    endtask

    function automatic int flags();
        return int'({rx_parity_err, rx_frame_err, rx_overrun});
    endfunction

    logic [15:0] mf;
    int          ml;
    int          f0;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_divisor = 11'd3;
        set_cfg(2'b11, 2'b00, 1'b0);
        w_data  = 8'h00;
        wr_uart = 1'b0;
        rd_uart = 1'b0;
        clr_err = 1'b0;
        tick_n(3);

        check("rst_tx", int'(tx), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_tx_full", int'(tx_full), 0);
        check("rst_rx_empty", int'(rx_empty), 1);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_flags", flags(), 0);

        ml = build_frame(8'hA5, 2'b11, 2'b00, 1'b0, mf);
        check("model_8n1_len", ml, 10);
        check("model_8n1_bits", int'(mf[9:0]), 'h34A);
        ml = build_frame(8'h35, 2'b10, 2'b01, 1'b1, mf);
        check("model_7e2_len", ml, 11);
        check("model_7e2_bits", int'(mf[10:0]), 'h66A);

        reset_n = 1'b1;
        tick_n(2);

        // Loopback 8N1 0xA5 with pop/fall latency
        loop   = 1'b1;
        mon_en = 1'b1;
        expect_tx(8'hA5);
        @(negedge clk);
        w_data  = 8'hA5;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
        check("a5_tx_before_pop", int'(tx), 1);
        check("a5_busy_before_pop", int'(tx_busy), 0);
        @(negedge clk);
        check("a5_tx_fall", int'(tx), 0);
        check("a5_busy", int'(tx_busy), 1);
        wait_tx_done("a5");
        wait_rx("a5");
        check("a5_flags", flags(), 0);
        pop_rx("a5_data", 8'hA5);
        check("a5_empty_after_pop", int'(rx_empty), 1);

        // Loopback 7E2 0x35
        set_cfg(2'b10, 2'b01, 1'b1);
        expect_tx(8'h35);
        uart_write(8'h35);
        wait_tx_done("7e2");
        wait_rx("7e2");
        check("7e2_flags", flags(), 0);
        pop_rx("7e2_data", 8'h35);

        // Bench-driven 7E2 with flipped parity
        loop = 1'b0;
        send_frame(8'h35, 1'b1, 1'b0);
        wait_rx("perr");
        check("perr_set", int'(rx_parity_err), 1);
        check("perr_no_ferr", int'(rx_frame_err), 0);
        check("perr_data", int'(rx_data), 'h35);
        clear_errs();
        check("perr_cleared", int'(rx_parity_err), 0);
        pop_rx("perr_pop", 8'h35);

        // 8N1 with stop bit low
        set_cfg(2'b11, 2'b00, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_rx("ferr");
        check("ferr_set", int'(rx_frame_err), 1);
        check("ferr_no_perr", int'(rx_parity_err), 0);
        pop_rx("ferr_data", 8'h3C);
        clear_errs();
        check("ferr_cleared", int'(rx_frame_err), 0);

        // Short low glitch on idle line
        rx_drv = 1'b0;
        tick_n(16);
        rx_drv = 1'b1;
        tick_n(1000);
        check("glitch_empty", int'(rx_empty), 1);
        check("glitch_flags", flags(), 0);

        // RX overrun: 17 bytes into a 16 deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
            if (i == 15) check("ovr_before", int'(rx_overrun), 0);
        end
        tick_n(100);
        check("ovr_set", int'(rx_overrun), 1);
        for (int i = 0; i < 16; i++)
            pop_rx($sformatf("ovr_fifo%0d", i), 8'(i));
        check("ovr_empty_after_16", int'(rx_empty), 1);

        // TX FIFO fill with consecutive writes
        f0 = frames_seen;
        for (int i = 0; i < 17; i++) expect_tx(8'(i));
        @(negedge clk);
        wr_uart = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w_data = 8'(i);
            @(negedge clk);
        end
        check("tx_full_17", int'(tx_full), 1);
        w_data = 8'hEE;
        @(negedge clk);
        wr_uart = 1'b0;
        check("tx_full_18", int'(tx_full), 1);
        wait_tx_done("txfifo");
        check("txfifo_frames", frames_seen - f0, 17);
        tick_n(300);
        check("txfifo_idle", int'(tx_busy), 0);
        check("txfifo_not_full", int'(tx_full), 0);

        // Reset mid-frame on both directions, overrun still set
        mon_en = 1'b0;
        uart_write(8'h77);
        rx_drv = 1'b0;
        tick_n(150);
        check("pre_rst_busy", int'(tx_busy), 1);
        check("pre_rst_ovr", int'(rx_overrun), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", int'(tx), 1);
        check("mid_rst_busy", int'(tx_busy), 0);
        check("mid_rst_empty", int'(rx_empty), 1);
        check("mid_rst_flags", flags(), 0);
        rx_drv = 1'b1;
        tick_n(3);
        reset_n = 1'b1;
        tick_n(5);

        loop   = 1'b1;
        mon_en = 1'b1;
        expect_tx(8'h5A);
        uart_write(8'h5A);
        wait_tx_done("post_rst");
        wait_rx("post_rst");
        check("post_rst_flags", flags(), 0);
        pop_rx("post_rst_data", 8'h5A);
        check("post_rst_empty", int'(rx_empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
